// File: rtl/bcd_cascade_timer.sv
// Coin-operated BCD countdown timer: ss/mm/hh digit cascade with prescaled
// one-second ticks, add-a-minute, pause/resume and a one-shot expiry pulse.
module bcd_cascade_timer #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Preset,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  AddMin,
    output logic [4*DIGITS-1:0]   Count,
    output logic                  Running,
    output logic                  Done,
    output logic                  Expired
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [W-1:0]  r_count, w_count_next, w_dec, w_add;
    logic [PW-1:0] r_presc, w_presc_next;
    logic          r_done, w_done_next, w_tick, w_add_en;

    // Seconds and minutes digits in the tens place count to 5; all others to 9.
    function automatic logic [3:0] f_max(input int unsigned i);
        return (i == 1 || i == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > f_max(i)) r[4*i +: 4] = f_max(i);
        return r;
    endfunction

    function automatic logic [W-1:0] f_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = f_max(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Carry out of the top digit saturates the whole display instead of wrapping.
    function automatic logic [W-1:0] f_addmin(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 2; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= f_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry)
            for (int unsigned i = 0; i < DIGITS; i++) r[4*i +: 4] = f_max(i);
        return r;
    endfunction

    always_comb begin
        w_tick   = (r_state == S_RUN) && Enable && (r_presc == P_TOP);
        w_add_en = AddMin && (DIGITS >= 3) && ((r_state == S_RUN) || (r_state == S_PAUSE));
        w_dec    = w_tick ? f_dec(r_count) : r_count;
        w_add    = w_add_en ? f_addmin(w_dec) : w_dec;
    end

    always_comb begin
        w_next       = r_state;
        w_count_next = w_add;
        w_presc_next = r_presc;
        w_done_next  = 1'b0;
        if ((r_state == S_RUN) && Enable)
            w_presc_next = w_tick ? '0 : r_presc + PW'(1);
        if (Load) begin
            w_next       = S_IDLE;
            w_count_next = f_clamp(Preset);
            w_presc_next = '0;
        end else begin
            case (r_state)
                S_IDLE, S_PAUSE: begin
                    if (!Stop && Start && (r_count != '0)) w_next = S_RUN;
                end
                S_RUN: begin
                    // Expiry outranks a simultaneous Stop.
                    if (w_add == '0) begin
                        w_next      = S_DONE;
                        w_done_next = 1'b1;
                    end else if (Stop) begin
                        w_next = S_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            r_presc <= w_presc_next;
            r_done  <= w_done_next;
        end
    end

    assign Count   = r_count;
    assign Running = (r_state == S_RUN);
    assign Expired = (r_state == S_DONE);
    assign Done    = r_done;

endmodule

// File: tb/tb_bcd_cascade_timer.sv
// Directed checks of bcd_cascade_timer with DIGITS=4, TICK_DIV=4.
module tb_bcd_cascade_timer;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        Enable = 1'b0;
    logic        Load = 1'b0;
    logic [15:0] Preset = '0;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic        AddMin = 1'b0;
    logic [15:0] Count;
    logic        Running, Done, Expired;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_cascade_timer #(.DIGITS(4), .TICK_DIV(4)) dut (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .Load(Load), .Preset(Preset),
        .Start(Start), .Stop(Stop), .AddMin(AddMin), .Count(Count),
        .Running(Running), .Done(Done), .Expired(Expired)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] p);
        Load = 1'b1; Preset = p; step(); Load = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1; step(); Start = 1'b0;
    endtask

    task automatic do_stop();
        Stop = 1'b1; step(); Stop = 1'b0;
    endtask

    task automatic do_addmin();
        AddMin = 1'b1; step(); AddMin = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        n_checks++; if (Count !== 16'h0000) begin n_fail++; $display("FAIL reset_count got=%h exp=0000", Count); end
        n_checks++; if ({Running, Done, Expired} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {Running, Done, Expired}); end
        nReset = 1'b1;
        step();
        do_start();
        n_checks++; if (Running !== 1'b0) begin n_fail++; $display("FAIL start_zero_ignored got=%b exp=0", Running); end
    endtask

    task automatic test_countdown();
        Enable = 1'b1;
        do_load(16'h0003);
        do_start();
        n_checks++; if ({Running, Done, Expired} !== 3'b100) begin n_fail++; $display("FAIL cd_running got=%b exp=100", {Running, Done, Expired}); end
        step(3);
        n_checks++; if (Count !== 16'h0003) begin n_fail++; $display("FAIL cd_pre_tick got=%h exp=0003", Count); end
        step();
        n_checks++; if (Count !== 16'h0002) begin n_fail++; $display("FAIL cd_tick1 got=%h exp=0002", Count); end
        step(4);
        n_checks++; if (Count !== 16'h0001) begin n_fail++; $display("FAIL cd_tick2 got=%h exp=0001", Count); end
        step(3);
        n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL cd_done_early got=%b exp=0", Done); end
        step();
        n_checks++; if (Count !== 16'h0000) begin n_fail++; $display("FAIL cd_tick3 got=%h exp=0000", Count); end
        n_checks++; if ({Running, Done, Expired} !== 3'b011) begin n_fail++; $display("FAIL cd_expire got=%b exp=011", {Running, Done, Expired}); end
        step();
        n_checks++; if ({Running, Done, Expired} !== 3'b001) begin n_fail++; $display("FAIL cd_done_pulse got=%b exp=001", {Running, Done, Expired}); end
        do_start();
        step(5);
        n_checks++; if ({Count, Running, Done, Expired} !== {16'h0000, 3'b001}) begin n_fail++; $display("FAIL cd_done_hold got=%h/%b exp=0000/001", Count, {Running, Done, Expired}); end
        do_load(16'h0005);
        n_checks++; if ({Count, Running, Expired} !== {16'h0005, 2'b00}) begin n_fail++; $display("FAIL cd_reload got=%h/%b exp=0005/00", Count, {Running, Expired}); end
    endtask

    task automatic test_borrow();
        Enable = 1'b1;
        do_load(16'h0100);
        do_start();
        step(4);
        n_checks++; if (Count !== 16'h0059) begin n_fail++; $display("FAIL borrow_0100 got=%h exp=0059", Count); end
        do_load(16'h1000);
        do_start();
        step(4);
        n_checks++; if (Count !== 16'h0959) begin n_fail++; $display("FAIL borrow_1000 got=%h exp=0959", Count); end
    endtask

    task automatic test_clamp_addmin();
        Enable = 1'b0;
        do_load(16'h9F7C);
        n_checks++; if (Count !== 16'h5959) begin n_fail++; $display("FAIL clamp got=%h exp=5959", Count); end
        do_start(); do_stop();
        do_addmin();
        n_checks++; if ({Count, Running} !== {16'h5959, 1'b0}) begin n_fail++; $display("FAIL addmin_sat_max got=%h/%b exp=5959/0", Count, Running); end
        do_load(16'h5930);
        do_start(); do_stop();
        do_addmin();
        n_checks++; if (Count !== 16'h5959) begin n_fail++; $display("FAIL addmin_sat_ovf got=%h exp=5959", Count); end
        do_load(16'h0959);
        do_addmin();
        n_checks++; if (Count !== 16'h0959) begin n_fail++; $display("FAIL addmin_idle_ignored got=%h exp=0959", Count); end
        do_start(); do_stop();
        do_addmin();
        n_checks++; if (Count !== 16'h1059) begin n_fail++; $display("FAIL addmin_carry got=%h exp=1059", Count); end
    endtask

    task automatic test_tick_addmin();
        Enable = 1'b1;
        do_load(16'h0001);
        do_start();
        step(3);
        do_addmin();
        n_checks++; if (Count !== 16'h0100) begin n_fail++; $display("FAIL tick_addmin_count got=%h exp=0100", Count); end
        n_checks++; if ({Running, Done, Expired} !== 3'b100) begin n_fail++; $display("FAIL tick_addmin_flags got=%b exp=100", {Running, Done, Expired}); end
    endtask

    task automatic test_stop_tick();
        Enable = 1'b1;
        do_load(16'h0002);
        do_start();
        step(3);
        do_stop();
        n_checks++; if ({Count, Running, Expired} !== {16'h0001, 2'b00}) begin n_fail++; $display("FAIL stop_tick_pause got=%h/%b exp=0001/00", Count, {Running, Expired}); end
        do_start();
        step(3);
        do_stop();
        n_checks++; if ({Count, Running, Done, Expired} !== {16'h0000, 3'b011}) begin n_fail++; $display("FAIL stop_tick_done got=%h/%b exp=0000/011", Count, {Running, Done, Expired}); end
    endtask

    task automatic test_enable_freeze();
        Enable = 1'b1;
        do_load(16'h0002);
        do_start();
        step(2);
        Enable = 1'b0;
        step(10);
        n_checks++; if ({Count, Running} !== {16'h0002, 1'b1}) begin n_fail++; $display("FAIL freeze_hold got=%h/%b exp=0002/1", Count, Running); end
        do_stop();
        do_start();
        Enable = 1'b1;
        step();
        n_checks++; if (Count !== 16'h0002) begin n_fail++; $display("FAIL freeze_presc_kept got=%h exp=0002", Count); end
        step();
        n_checks++; if (Count !== 16'h0001) begin n_fail++; $display("FAIL freeze_resume_tick got=%h exp=0001", Count); end
        step(4);
        n_checks++; if ({Count, Done, Expired} !== {16'h0000, 2'b11}) begin n_fail++; $display("FAIL freeze_finish got=%h/%b exp=0000/11", Count, {Done, Expired}); end
    endtask

    task automatic test_reset_midrun();
        Enable = 1'b1;
        do_load(16'h0042);
        do_start();
        step(2);
        nReset = 1'b0;
        #1;
        n_checks++; if ({Count, Running, Done, Expired} !== {16'h0000, 3'b000}) begin n_fail++; $display("FAIL async_reset got=%h/%b exp=0000/000", Count, {Running, Done, Expired}); end
        step();
        nReset = 1'b1;
        step();
        do_start();
        step(4);
        n_checks++; if ({Count, Running} !== {16'h0000, 1'b0}) begin n_fail++; $display("FAIL reset_start_ignored got=%h/%b exp=0000/0", Count, Running); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_clamp_addmin();
        test_tick_addmin();
        test_stop_tick();
        test_enable_freeze();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
